bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
//   Sits directly upstream of the per-digit 7-segment decoders: each 4-bit
//   digit of bcd drives one decoder's 4-bit input.
//   Every digit it emits is 0..9, so the decoders never see an invalid code.
// PARAMETERS
//   BIN_W   10  width of the binary input value
//   DIGITS  4   number of BCD output digits; digit 0 is the least significant
// PORTS
//   clk     in   1           system clock; rising-edge active
//   rst_n   in   1           asynchronous active-low reset
//   start   in   1           conversion request; sampled when busy==0
//   bin     in   BIN_W       binary value; captured on an accepted start
//   busy    out  1           conversion in progress
//   done    out  1           one-cycle pulse; bcd updated in the same cycle
//   bcd     out  4*DIGITS    result; digit k occupies bcd[4k+3:4k]
//   blank   out  DIGITS      only with LEADING_ZERO_BLANK_EN (see CONFIGURATION)
//   Clocking/reset: one clock; reset is asynchronous and active-low.
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd=0,
//     blank=all-ones except bit 0, internal shift regs and counter cleared.
//   Reset asserted mid-conversion aborts it; no done pulse follows.
//   FSM states IDLE, SHIFT, DONE:
//     IDLE : start=1 -> capture bin, clear scratch, cnt=BIN_W, go to SHIFT.
//     SHIFT: busy=1. Each cycle:
//       - add 3 to every scratch digit >=5;
//       - shift {scratch,binreg} left by 1, binreg MSB entering scratch LSB;
//       - decrement cnt. When cnt reaches 1 (last shift), go to DONE.
//     DONE : busy=0, done=1 for exactly this cycle; bcd<=scratch.
//            start=1 here is accepted (back-to-back) -> SHIFT; else IDLE.
//   Latency: start accepted at edge N -> done high in the cycle after edge
//     N+BIN_W (BIN_W+1 cycles). Throughput: one result per BIN_W+1 cycles.
//   start while busy=1 is ignored; bin is not re-sampled.
//   bcd holds the previous result during a conversion. It changes only in
//     the done cycle, so the decoders never see intermediate values.
//   Width rule: elaboration fails (generate-time $error) unless
//     10^DIGITS > 2^BIN_W - 1. This makes overflow impossible.
//   bin=0 is legal: the result is all-zero digits, with normal latency.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     - port blank[DIGITS-1:0] exists and is registered with bcd, updating
//       in the done cycle.
//     - blank[k]=1 iff digit k and all higher digits are zero.
//     - blank[0] is forced to 0, so the value 0 shows a single "0".
//     - Downstream uses blank to switch a digit's segments off.
//   LEADING_ZERO_BLANK_EN undefined:
//     - blank port and its logic are absent; all digits are always driven.
// TESTING
//   1 rst_n=0 mid-SHIFT -> busy=0, done=0, bcd=16'h0000 at once, asynchronously;
//     no done pulse after release.
//   2 BIN_W=10, DIGITS=4, bin=937, start 1 cycle -> busy for 10 cycles, done
//     high in cycle 11, bcd=16'h0937.
//   3 bin=1023 -> bcd=16'h1023. Then bin=0 -> bcd=16'h0000. Each has latency 11.
//   4 start held high with bin changed during SHIFT -> ignored. Result equals
//     the value captured at the accepted start; done pulses once.
//   5 start=1 in the done cycle with bin=42 -> next conversion starts with no
//     IDLE gap; second done exactly 11 cycles after the first; bcd=16'h0042.
//   6 LEADING_ZERO_BLANK_EN:
//     - bin=7 -> blank=4'b1110
//     - bin=0 -> blank=4'b1110
//     - bin=1000 -> blank=4'b0000

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking output enabled by LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef LEADING_ZERO_BLANK_EN
   ,output logic [DIGITS-1:0]     blank
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    // Too few digits could overflow, so refuse to elaborate.
    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_width_check
            $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   binreg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_shf;
    logic [CNT_W-1:0]   cnt;

    // Add-3 correction on every digit >= 5, then shift in the next binary bit.
    always_comb begin
        scratch_adj = scratch;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
        scratch_shf = {scratch_adj[BCD_W-2:0], binreg[BIN_W-1]};
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;

    // A digit blanks when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_above   = zero_above & (scratch_shf[4*k +: 4] == 4'd0);
            blank_nxt[k] = zero_above;
        end
        blank_nxt[0] = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            binreg  <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        binreg  <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_shf;
                    binreg  <= {binreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= scratch_shf;
`ifdef LEADING_ZERO_BLANK_EN
                        blank <= blank_nxt;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (BIN_W=10, DIGITS=4) against an arithmetic model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]  blank;
`endif

    int          n_checks;
    int          n_fails;
    logic [15:0] last_exp;

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef LEADING_ZERO_BLANK_EN
       ,.blank (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_model(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] blank_model(input int v);
        logic [3:0] r;
        int p;
        r = '0;
        p = 10;
        for (int k = 1; k < 4; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [9:0] v, input bit hold);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge; returns at the done-cycle negedge.
    task automatic wait_done(input string tag, input logic [9:0] v, input bit hold);
        int lat;
        int busy_cnt;
        bit found;
        lat = -1;
        busy_cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (i > 0) @(negedge clk);
            if (hold) begin
                bin = 10'($urandom_range(0, 1023));
                if (i == 8) start = 1'b0;
            end
            if (i == 5) check({tag, " bcd_hold"}, 32'(bcd), 32'(last_exp));
            if (busy) busy_cnt++;
            if (done) begin
                found = 1'b1;
                lat = i;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd10);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd10);
        check({tag, " bcd"}, 32'(bcd), 32'(bcd_model(int'(v))));
`ifdef LEADING_ZERO_BLANK_EN
        check({tag, " blank"}, 32'(blank), 32'(blank_model(int'(v))));
`endif
        last_exp = bcd_model(int'(v));
    endtask

    initial begin
        bit seen_done;
        logic [9:0] v;
        n_checks = 0;
        n_fails  = 0;
        last_exp = '0;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;

        #3;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset bcd", 32'(bcd), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        check("reset blank", 32'(blank), 32'b1110);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        issue(10'd937, 1'b0);
        wait_done("conv937", 10'd937, 1'b0);
        @(negedge clk);
        check("conv937 done_once", 32'(done), 32'd0);

        issue(10'd1023, 1'b0);
        wait_done("conv1023", 10'd1023, 1'b0);
        issue(10'd0, 1'b0);
        wait_done("conv0", 10'd0, 1'b0);

        // start held with bin wandering during the shift
        issue(10'd618, 1'b1);
        wait_done("hold618", 10'd618, 1'b1);
        @(negedge clk);
        check("hold done_once", 32'(done), 32'd0);
        check("hold idle", 32'(busy), 32'd0);

        // back-to-back: request in the done cycle
        issue(10'd555, 1'b0);
        wait_done("b2b_first", 10'd555, 1'b0);
        start = 1'b1;
        bin   = 10'd42;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy_now", 32'(busy), 32'd1);
        wait_done("b2b_second", 10'd42, 1'b0);

`ifdef LEADING_ZERO_BLANK_EN
        issue(10'd7, 1'b0);
        wait_done("blank7", 10'd7, 1'b0);
        issue(10'd1000, 1'b0);
        wait_done("blank1000", 10'd1000, 1'b0);
`endif

        // asynchronous reset mid-shift
        issue(10'd500, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort bcd", 32'(bcd), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        check("abort blank", 32'(blank), 32'b1110);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort no_done", 32'(seen_done), 32'd0);
        check("abort idle", 32'(busy), 32'd0);
        last_exp = '0;

        for (int n = 0; n < 10; n++) begin
            v = 10'($urandom_range(0, 1023));
            issue(v, 1'b0);
            wait_done("random", v, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
